uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter, the transmit-side counterpart of `uart_rx` in the same serial link. It accepts one byte per valid/ready handshake and serialises it onto `tx_o` as start bit, data LSB-first, optional parity and one or two stop bits, at a fixed baud rate derived from the clock frequency. Frame format matches the receiver's controls, so a `uart_tx` → `uart_rx` loopback with identical settings is lossless.

## Interface
- `p_clk_speed_hz`, 50_000_000, input clock frequency in Hz.
- `p_baud_rate`, 9_600, line bit rate.
- `clk_i` input 1: single clock; all logic on rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `enable_i` input 1: permits leaving IDLE; frame in progress always completes.
- `data_i` input 8: byte to send, sampled on handshake.
- `valid_i` input 1: `data_i` valid; transfer when `valid_i & ready_o`.
- `ready_o` output 1: high only in IDLE with `enable_i` high.
- `parity_en_i` input 1: 1 = append parity bit.
- `parity_sel_i` input 1: 1 = even parity, 0 = odd.
- `stop_bits_i` input 1: 0 = one stop bit, 1 = two.
- `tx_o` output 1: serial line, idle high, registered.
- `busy_o` output 1: high from handshake cycle +1 until frame end.
- `done_o` output 1: one-cycle pulse at end of last stop bit.

## Operation
- DIV = p_clk_speed_hz / p_baud_rate (integer, truncated); bit counter width $clog2(DIV); DIV < 2 is illegal (elaboration `$error`).
- States: IDLE → START → DATA → [PARITY] → STOP1 → [STOP2] → IDLE.
- IDLE: `tx_o`=1. On handshake latch data, `parity_en_i`, `parity_sel_i`, `stop_bits_i` into shadow registers; config changes mid-frame have no effect.
- START: `tx_o`=0 for DIV cycles.
- DATA: N bits LSB-first, DIV cycles each, bit index 0..N-1 (N=8, see Configuration).
- PARITY (if latched enable): even → XOR of data bits; odd → inverted XOR.
- STOP1/STOP2: `tx_o`=1, DIV cycles each; STOP2 only if latched `stop_bits_i`=1.
- Leaving last stop bit: `done_o`=1 for that cycle, `busy_o` drops, state → IDLE.
- `enable_i` low mid-frame: ignored until IDLE; then `ready_o`=0.

## Timing
- Reset values: `tx_o`=1, `ready_o`=0 (asserted next cycle if `enable_i`), `busy_o`=0, `done_o`=0, state IDLE, counters 0.
- Handshake in cycle T: `tx_o` falls, `busy_o` rises, `ready_o` falls at edge T+1.
- Each bit holds exactly DIV cycles; frame = DIV × (1 + N + P + S) cycles, P∈{0,1}, S∈{1,2}.
- `done_o` pulses in last cycle of final stop bit; `ready_o` high the following cycle. Min inter-frame gap: 1 idle cycle (`tx_o`=1).
- `valid_i` while busy: ignored, no back-pressure loss (source must hold until `ready_o`).
- Reset asserted mid-frame: `tx_o`=1 immediately (asynchronous), frame abandoned, no `done_o`.

## Configuration
- `UART_TX_DATA7_EN`: defined → N=7; `data_i[6:0]` sent, `data_i[7]` ignored and excluded from parity. Undefined → N=8, full `data_i` sent. Matches receiver 7-bit build.

## Test plan
- Reset: assert `rst_i` mid-frame of 0x55 → `tx_o`=1 same cycle, `busy_o`=0, no `done_o`; after release `ready_o`=1 with `enable_i`=1.
- 8E1, `data_i`=0x48 ('H'), DIV=5208 → line 0,0,0,0,1,0,0,1,0,0(parity),1; `done_o` at cycle 57288 after handshake.
- 8O2, `data_i`=0x45 ('E') → parity bit 0, two stop bits, frame 12×5208 cycles, `busy_o` high throughout.
- 8N1 back-to-back "HELLO" with `valid_i` held → 5 frames, each 10×DIV, 1-cycle idle gap, loopback `uart_rx` returns same bytes, no errors.
- Config change mid-frame (toggle `parity_en_i`, `stop_bits_i` during DATA) → frame unchanged; `valid_i` during busy ignored; `enable_i`=0 → `ready_o`=0 after frame, `tx_o` stays 1.
- With `UART_TX_DATA7_EN`, even parity, `data_i`=0xC1 → 7 data bits 1,0,0,0,0,0,1, parity 0, frame 10×DIV.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Purpose:
//   UART transmitter. Accepts one byte per valid/ready handshake and
//   serialises it on tx_o as: start bit, data bits LSB-first, an optional
//   parity bit, then one or two stop bits. Each bit lasts DIV clock cycles,
//   where DIV = p_clk_speed_hz / p_baud_rate (truncated). The frame format
//   matches the uart_rx controls, so a loopback with identical settings is
//   lossless.
//
// Optional feature macro:
//   UART_TX_DATA7_EN : when defined, frames carry 7 data bits (data_i[6:0]).
//                      data_i[7] is not sent and is excluded from parity.
//                      When undefined, frames carry all 8 bits of data_i.
//
// Parameters:
//   p_clk_speed_hz : input clock frequency in Hz
//   p_baud_rate    : line bit rate
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous reset, active high
//   enable_i     in   permits leaving IDLE; a frame in progress always completes
//   data_i[7:0]  in   byte to send, sampled on the handshake
//   valid_i      in   data_i valid
//   ready_o      out  high only in IDLE with enable_i high
//   parity_en_i  in   1 = append parity bit
//   parity_sel_i in   1 = even parity, 0 = odd parity
//   stop_bits_i  in   0 = one stop bit, 1 = two stop bits
//   tx_o         out  serial line, idle high, registered
//   busy_o       out  high from the cycle after the handshake until frame end
//   done_o       out  one-cycle pulse in the last cycle of the final stop bit
//   state_o[2:0] out  debug view of the FSM state register
//
// Handshake: a byte transfers on a rising edge where valid_i and ready_o are
// both high. The source must hold valid_i and data_i stable until then;
// valid_i while the transmitter is busy is simply not accepted.
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int p_clk_speed_hz = 50_000_000,
    parameter int p_baud_rate    = 9_600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       parity_en_i,
    input  logic       parity_sel_i,
    input  logic       stop_bits_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] state_o
);

    localparam int DIV = p_clk_speed_hz / p_baud_rate;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

`ifdef UART_TX_DATA7_EN
    localparam int N = 7;
`else
    localparam int N = 8;
`endif

    localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(N - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx: p_clk_speed_hz / p_baud_rate must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [N-1:0]    data_q;
    logic            par_en_q;
    logic            par_even_q;
    logic            two_stop_q;
    logic            tx_q, tx_d;
    logic            busy_q;
    logic            ready_q;
    logic            handshake;
    logic            bit_end;
    logic            parity_bit;
    logic            done;

    // ready_q says "state is IDLE"; gating with enable_i here makes a drop
    // of enable_i take effect in the same cycle.
    assign ready_o    = ready_q & enable_i;
    assign handshake  = valid_i & ready_o & (state_q == S_IDLE);
    assign bit_end    = (cnt_q == BIT_LAST);
    // Even parity = XOR of the data bits; odd parity is its inverse.
    assign parity_bit = (^data_q) ^ ~par_even_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        idx_d   = idx_q;
        done    = 1'b0;

        // The bit-time counter runs in every non-idle state and wraps at
        // the end of each bit.
        if (state_q != S_IDLE && !bit_end) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (bit_end) begin
                    if (two_stop_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // tx_o is registered, so the line level is decoded from the state
        // being entered; this makes tx_o fall on the handshake edge itself.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_q[idx_d];
            S_PARITY: tx_d = parity_bit;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != S_IDLE);
            ready_q <= (state_d == S_IDLE);
            // Shadow copies: the frame in flight ignores later input changes.
            if (handshake) begin
                data_q     <= data_i[N-1:0];
                par_en_q   <= parity_en_i;
                par_even_q <= parity_sel_i;
                two_stop_q <= stop_bits_i;
            end
        end
    end

    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign done_o  = done;
    assign state_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Self-checking bench for uart_tx. Runs with a small bit time
// (100 Hz clock / 12 baud -> DIV = 8 after truncation) so every frame is short.
// Expected line bits, frame lengths and start cycles are queued when a byte
// is handed over and checked by a line monitor as the DUT transmits.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CLK_HZ = 100;
    localparam int BAUD   = 12;
    localparam int DIV    = 8;   // 100 / 12 truncated

`ifdef UART_TX_DATA7_EN
    localparam int N = 7;
`else
    localparam int N = 8;
`endif

    logic       clk;
    logic       rst_i;
    logic       enable_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       parity_en_i;
    logic       parity_sel_i;
    logic       stop_bits_i;
    logic       tx_o;
    logic       busy_o;
    logic       done_o;
    logic [2:0] state_o;

    uart_tx #(
        .p_clk_speed_hz(CLK_HZ),
        .p_baud_rate   (BAUD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .parity_en_i (parity_en_i),
        .parity_sel_i(parity_sel_i),
        .stop_bits_i (stop_bits_i),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .state_o     (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int         len_q[$];
    int         start_q[$];

    task automatic push_frame(input logic [7:0] d, input logic pen, input logic psel,
                              input logic two, input int hs);
        logic [7:0] dm;
        logic       p;
        dm = d;
        if (N == 7) dm[7] = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < N; i++) exp_q.push_back(dm[i]);
        p = ^dm;
        if (!psel) p = ~p;
        if (pen) exp_q.push_back(p);
        exp_q.push_back(1'b1);
        if (two) exp_q.push_back(1'b1);
        len_q.push_back(DIV * (1 + N + (pen ? 1 : 0) + (two ? 2 : 1)));
        start_q.push_back(hs + 1);
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic pen, input logic psel,
                        input logic two, input logic hold, output int hs);
        int waited;
        waited       = 0;
        hs           = -1;
        data_i       = d;
        parity_en_i  = pen;
        parity_sel_i = psel;
        stop_bits_i  = two;
        valid_i      = 1'b1;
        while (hs < 0 && waited < 30 * DIV) begin
            @(negedge clk);
            if (ready_o) begin
                hs = cyc_cnt;
                push_frame(d, pen, psel, two, hs);
            end
            waited++;
        end
        if (hs < 0) check("send_timeout", 1, 0);
        @(posedge clk); #1;
        valid_i = hold;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while ((busy_o || exp_q.size() != 0) && w < 20 * DIV) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20 * DIV) check("idle_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    // ---------------- line monitor ----------------
    bit   mon_in_frame = 1'b0;
    logic mon_prev_tx  = 1'b1;
    int   mon_fc       = 0;
    bit   mon_busy_ok  = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_i) begin
                mon_in_frame = 1'b0;
                mon_prev_tx  = 1'b1;
            end else begin
                if (!mon_in_frame && mon_prev_tx && !tx_o) begin
                    mon_in_frame = 1'b1;
                    mon_fc       = 0;
                    mon_busy_ok  = 1'b1;
                    if (start_q.size() == 0) check("unexpected_frame", 1, 0);
                    else check("start_cycle", cyc_cnt, start_q.pop_front());
                end
                if (mon_in_frame) begin
                    mon_fc++;
                    if (!busy_o) mon_busy_ok = 1'b0;
                    if ((mon_fc - 1) % DIV == DIV / 2) begin
                        if (exp_q.size() == 0) check("extra_bit", 1, 0);
                        else check("line_bit", tx_o, exp_q.pop_front());
                    end
                    if (done_o) begin
                        if (len_q.size() == 0) check("extra_done", 1, 0);
                        else check("frame_len", mon_fc, len_q.pop_front());
                        check("busy_in_frame", mon_busy_ok, 1);
                        mon_in_frame = 1'b0;
                    end else if (mon_fc > 14 * DIV) begin
                        check("done_timeout", 1, 0);
                        mon_in_frame = 1'b0;
                    end
                end else if (done_o) begin
                    check("stray_done", 1, 0);
                end
                mon_prev_tx = tx_o;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] msg [5];
    int         hs;
    int         prev_hs;

    initial begin
        msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        rst_i        = 1'b1;
        enable_i     = 1'b1;
        valid_i      = 1'b0;
        data_i       = 8'h00;
        parity_en_i  = 1'b0;
        parity_sel_i = 1'b0;
        stop_bits_i  = 1'b0;
        prev_hs      = 0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", tx_o, 1);
        check("rst_ready", ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_state", state_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_rel_same_cycle", ready_o, 0);
        @(negedge clk);
        check("ready_after_rel", ready_o, 1);
        @(posedge clk); #1;

        // 8E1 'H' -> parity 0
        send(8'h48, 1'b1, 1'b1, 1'b0, 1'b0, hs);
        wait_idle();

        // 8O2 'E' -> parity 0, two stop bits
        send(8'h45, 1'b1, 1'b0, 1'b1, 1'b0, hs);
        wait_idle();

        // 8N1 back-to-back "HELLO" with valid_i held: one idle cycle between frames
        for (int i = 0; i < 5; i++) begin
            send(msg[i], 1'b0, 1'b0, 1'b0, (i < 4), hs);
            if (i > 0) check("b2b_spacing", hs - prev_hs, DIV * (2 + N) + 1);
            prev_hs = hs;
        end
        wait_idle();

        // Config and data changes mid-frame, plus valid_i while busy
        send(8'hA7, 1'b1, 1'b1, 1'b0, 1'b0, hs);
        repeat (3 * DIV) @(posedge clk);
        #1;
        parity_en_i  = 1'b0;
        parity_sel_i = 1'b0;
        stop_bits_i  = 1'b1;
        data_i       = 8'h00;
        valid_i      = 1'b1;
        repeat (DIV) @(posedge clk);
        #1;
        valid_i = 1'b0;
        wait_idle();

        // Even parity 0xC1 (7 data bits 1,0,0,0,0,0,1 in the 7-bit build)
        send(8'hC1, 1'b1, 1'b1, 1'b0, 1'b0, hs);
        wait_idle();

        // enable_i dropped mid-frame with valid_i still high
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, hs);
        repeat (2 * DIV) @(posedge clk);
        #1;
        enable_i = 1'b0;
        wait_idle();
        for (int k = 0; k < 3; k++) begin
            repeat (DIV) @(negedge clk);
            check("disabled_ready", ready_o, 0);
            check("disabled_tx", tx_o, 1);
        end
        @(posedge clk); #1;
        valid_i  = 1'b0;
        enable_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_reenable", ready_o, 1);
        @(posedge clk); #1;

        // Reset in the middle of a 0x55 frame
        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, hs);
        repeat (4 * DIV) @(posedge clk);
        #1;
        rst_i = 1'b1;
        exp_q.delete();
        len_q.delete();
        start_q.delete();
        #1;
        check("midrst_tx", tx_o, 1);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_ready", ready_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_midrst", ready_o, 1);
        check("tx_after_midrst", tx_o, 1);
        @(posedge clk); #1;

        // Recovery frame after reset: 8E2 0x5A
        send(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, hs);
        wait_idle();

        repeat (2 * DIV) @(negedge clk);
        check("queues_drained", exp_q.size() + len_q.size() + start_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
